// File: rtl/pipeline_stall_controller.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait FSM, hazard watchdog and
// optional performance counters (enabled by defining STALL_PERF_CNT_EN).
module pipeline_stall_controller #(
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             mem_start,
    output logic             freeze_all,
    output logic             freeze_if,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_id_ex,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    localparam logic [CNT_W-1:0] MaxStall = CNT_W'(MAX_STALL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             stall_err_q, stall_err_d;

    always_comb begin
        state_d      = state_q;
        mem_start    = 1'b0;
        freeze_all   = 1'b0;
        freeze_if    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        bubble_id_ex = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_req) begin
                    mem_start = 1'b1;
                    if (!mem_ready) begin
                        freeze_all = 1'b1;
                        state_d    = StMemWait;
                    end
                end
            end
            StMemWait: begin
                freeze_all = !mem_ready;
                if (mem_ready) state_d = StRun;
            end
            default: state_d = StRun;
        endcase

        // Priority: freeze_all, then branch flush, then hazard bubble.
        if (!freeze_all) begin
            if (branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (hazard_detected) begin
                freeze_if    = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end

        // Outputs drop in the same cycle reset is asserted, not at the next edge.
        if (!rst) begin
            mem_start    = 1'b0;
            freeze_all   = 1'b0;
            freeze_if    = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            bubble_id_ex = 1'b0;
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (freeze_all) begin
            wd_d = wd_q;
        end else if (freeze_if) begin
            wd_d = (wd_q >= MaxStall) ? MaxStall : wd_q + CNT_W'(1);
        end else begin
            wd_d = '0;
        end
        stall_err_d = stall_err_q | (wd_d == MaxStall);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            wd_q        <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((freeze_all || freeze_if) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (flush_if_id && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller; counter checks follow
// STALL_PERF_CNT_EN when it is defined for the build.
module tb_pipeline_stall_controller;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             hazard_detected = 1'b0;
    logic             branch_taken = 1'b0;
    logic             mem_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_start, freeze_all, freeze_if;
    logic             flush_if_id, flush_id_ex, bubble_id_ex, stall_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [5:0]       ctl;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic perf_en;

    pipeline_stall_controller #(.MAX_STALL(8), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .mem_start       (mem_start),
        .freeze_all      (freeze_all),
        .freeze_if       (freeze_if),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .bubble_id_ex    (bubble_id_ex),
        .stall_err       (stall_err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    // {mem_start, freeze_all, freeze_if, flush_if_id, flush_id_ex, bubble_id_ex}
    assign ctl = {mem_start, freeze_all, freeze_if, flush_if_id, flush_id_ex, bubble_id_ex};

    task automatic set_in(input logic rq, input logic rd, input logic br, input logic hz);
        @(negedge clk);
        mem_req         = rq;
        mem_ready       = rd;
        branch_taken    = br;
        hazard_detected = hz;
        #1;
    endtask

    task automatic test_reset;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b000000 || stall_err !== 1'b0) begin
            $display("FAIL reset_outputs: ctl=%b err=%b, want ctl=000000 err=0", ctl, stall_err);
            n_fail++;
        end
        n_cmp++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            $display("FAIL reset_counters: stall=%0d flush=%0d, want 0/0", stall_cycles, flush_count);
            n_fail++;
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b110000) begin
            $display("FAIL midwait_start: ctl=%b, want 110000", ctl);
            n_fail++;
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (ctl !== 6'b010000) begin
                $display("FAIL midwait_hold%0d: ctl=%b, want 010000", i, ctl);
                n_fail++;
            end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 6'b000000) begin
            $display("FAIL midwait_async_drop: ctl=%b, want 000000", ctl);
            n_fail++;
        end
        n_cmp++;
        if (stall_cycles !== '0 || flush_count !== '0 || stall_err !== 1'b0) begin
            $display("FAIL midwait_counters: stall=%0d flush=%0d err=%b, want 0/0/0",
                     stall_cycles, flush_count, stall_err);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        // Zero-wait from RUN gives mem_start without freeze; MEM_WAIT would not.
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b100000) begin
            $display("FAIL midwait_back_in_run: ctl=%b, want 100000", ctl);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_wait;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b110000) begin
            $display("FAIL load_t0: ctl=%b, want 110000", ctl);
            n_fail++;
        end
        for (int i = 1; i <= 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (ctl !== 6'b010000) begin
                $display("FAIL load_t%0d: ctl=%b, want 010000", i, ctl);
                n_fail++;
            end
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b000000) begin
            $display("FAIL load_t3_ready: ctl=%b, want 000000", ctl);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b000000) begin
            $display("FAIL load_after: ctl=%b, want 000000", ctl);
            n_fail++;
        end
        exp_stall += 3;
        n_cmp++;
        if (stall_cycles !== (perf_en ? CNT_W'(exp_stall) : '0)) begin
            $display("FAIL load_stall_cycles: got %0d, want %0d", stall_cycles,
                     perf_en ? exp_stall : 0);
            n_fail++;
        end
    endtask

    task automatic test_zero_wait;
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b100000) begin
            $display("FAIL zero_wait: ctl=%b, want 100000", ctl);
            n_fail++;
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b000000) begin
            $display("FAIL stray_ready: ctl=%b, want 000000", ctl);
            n_fail++;
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b100000) begin
            $display("FAIL zero_wait_still_run: ctl=%b, want 100000", ctl);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hazard;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (ctl !== 6'b001001) begin
                $display("FAIL hazard_c%0d: ctl=%b, want 001001", i, ctl);
                n_fail++;
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (ctl !== 6'b000000 || stall_err !== 1'b0) begin
            $display("FAIL hazard_end: ctl=%b err=%b, want 000000/0", ctl, stall_err);
            n_fail++;
        end
        exp_stall += 2;
        n_cmp++;
        if (stall_cycles !== (perf_en ? CNT_W'(exp_stall) : '0)) begin
            $display("FAIL hazard_stall_cycles: got %0d, want %0d", stall_cycles,
                     perf_en ? exp_stall : 0);
            n_fail++;
        end
    endtask

    task automatic test_branch_hazard;
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (ctl !== 6'b000110) begin
            $display("FAIL branch_over_hazard: ctl=%b, want 000110", ctl);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        exp_flush += 1;
        n_cmp++;
        if (flush_count !== (perf_en ? CNT_W'(exp_flush) : '0)) begin
            $display("FAIL branch_flush_count: got %0d, want %0d", flush_count,
                     perf_en ? exp_flush : 0);
            n_fail++;
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (ctl !== 6'b110000) begin
            $display("FAIL freeze_over_branch_run: ctl=%b, want 110000", ctl);
            n_fail++;
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (ctl !== 6'b010000) begin
            $display("FAIL freeze_over_branch_wait: ctl=%b, want 010000", ctl);
            n_fail++;
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        exp_stall += 2;
        n_cmp++;
        if (flush_count !== (perf_en ? CNT_W'(exp_flush) : '0) ||
            stall_cycles !== (perf_en ? CNT_W'(exp_stall) : '0)) begin
            $display("FAIL frozen_counters: flush=%0d stall=%0d, want %0d/%0d", flush_count,
                     stall_cycles, perf_en ? exp_flush : 0, perf_en ? exp_stall : 0);
            n_fail++;
        end
    endtask

    task automatic test_watchdog;
        for (int i = 0; i < 7; i++) set_in(1'b0, 1'b0, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (stall_err !== 1'b0) begin
            $display("FAIL wd_seven_cycles: err=%b, want 0", stall_err);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (stall_err !== 1'b0) begin
                $display("FAIL wd_early_c%0d: err=%b, want 0", i, stall_err);
                n_fail++;
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (stall_err !== 1'b1) begin
            $display("FAIL wd_trip: err=%b, want 1", stall_err);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (stall_err !== 1'b1) begin
            $display("FAIL wd_sticky: err=%b, want 1", stall_err);
            n_fail++;
        end
        exp_stall += 15;
        n_cmp++;
        if (stall_cycles !== (perf_en ? CNT_W'(exp_stall) : '0)) begin
            $display("FAIL wd_stall_cycles: got %0d, want %0d", stall_cycles,
                     perf_en ? exp_stall : 0);
            n_fail++;
        end
    endtask

    task automatic test_saturation;
        logic [CNT_W-1:0] all_ones;
        all_ones = '1;
`ifdef STALL_PERF_CNT_EN
        @(negedge clk);
        force dut.flush_count_q = all_ones;
        #1 release dut.flush_count_q;
`endif
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (flush_count !== (perf_en ? all_ones : '0)) begin
            $display("FAIL flush_saturate: got %0h, want %0h", flush_count,
                     perf_en ? all_ones : '0);
            n_fail++;
        end
    endtask

    task automatic test_reset_clears_err;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (stall_err !== 1'b0 || flush_count !== '0) begin
            $display("FAIL reset_clears: err=%b flush=%0d, want 0/0", stall_err, flush_count);
            n_fail++;
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
`ifdef STALL_PERF_CNT_EN
        perf_en = 1'b1;
`else
        perf_en = 1'b0;
`endif
        test_reset();
        test_reset_mid_wait();
        test_load_wait();
        test_zero_wait();
        test_hazard();
        test_branch_hazard();
        test_watchdog();
        test_saturation();
        test_reset_clears_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
